// File: rtl/frame_draw_if.sv
// Framebuffer write port, drawing-client handshakes and frame status of frame_draw_scheduler.
// master = scheduler side, slave = frame-edge detector / clients / framebuffer side.
interface frame_draw_if #(
  parameter int NCLIENT = 2
);
  localparam int NC = (NCLIENT > 0) ? NCLIENT : 1;

  logic             frame_start;
  logic [NC-1:0]    cl_start;
  logic [NC-1:0]    cl_valid;
  logic [NC-1:0]    cl_done;
  logic [10*NC-1:0] cl_x;
  logic [10*NC-1:0] cl_y;
  logic [8*NC-1:0]  cl_color;
  logic [9:0]       draw_x;
  logic [9:0]       draw_y;
  logic [7:0]       draw_color;
  logic             draw_we;
  logic             swap_req;
  logic             busy;
  logic [7:0]       overrun_cnt;

  modport master (
    input  frame_start, cl_valid, cl_done, cl_x, cl_y, cl_color,
    output cl_start, draw_x, draw_y, draw_color, draw_we, swap_req, busy, overrun_cnt
  );

  modport slave (
    output frame_start, cl_valid, cl_done, cl_x, cl_y, cl_color,
    input  cl_start, draw_x, draw_y, draw_color, draw_we, swap_req, busy, overrun_cnt
  );
endinterface

// File: rtl/frame_draw_scheduler.sv
// Per-frame owner of the framebuffer write port: clear the back buffer, serve the
// drawing clients in index order, then request a buffer swap.
module frame_draw_scheduler #(
  parameter int         W        = 320,
  parameter int         H        = 240,
  parameter int         NCLIENT  = 2,
  parameter logic [7:0] BG_COLOR = 8'h00,
  parameter logic [7:0] TRANSP   = 8'hFF
) (
  input  logic         Clk,
  input  logic         Reset,
  frame_draw_if.master bus
);
  localparam int             NC       = (NCLIENT > 0) ? NCLIENT : 1;
  localparam int             IW       = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [9:0]     W_L      = 10'(W);
  localparam logic [9:0]     H_L      = 10'(H);
  localparam logic [9:0]     X_LAST   = 10'(W - 1);
  localparam logic [9:0]     Y_LAST   = 10'(H - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_CLIENT = 2'd2,
    ST_SWAP   = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [IW-1:0] idx_r, idx_s;
  logic [NC-1:0] cl_start_r, cl_start_s;
  logic [9:0]    draw_x_r, draw_x_s;
  logic [9:0]    draw_y_r, draw_y_s;
  logic [7:0]    draw_color_r, draw_color_s;
  logic          draw_we_r, draw_we_s;
  logic          swap_req_r, swap_req_s;
  logic          busy_r, busy_s;
  logic [7:0]    overrun_r, overrun_s;

  logic          sel_valid_s;
  logic          sel_done_s;
  logic [9:0]    sel_x_s;
  logic [9:0]    sel_y_s;
  logic [7:0]    sel_c_s;
  logic          pix_ok_s;

  // Only the client owning the port is looked at; its pixel is kept if on-screen and opaque.
  always_comb begin
    sel_valid_s = bus.cl_valid[idx_r];
    sel_done_s  = bus.cl_done[idx_r];
    sel_x_s     = bus.cl_x[int'(idx_r) * 10 +: 10];
    sel_y_s     = bus.cl_y[int'(idx_r) * 10 +: 10];
    sel_c_s     = bus.cl_color[int'(idx_r) * 8 +: 8];
    pix_ok_s    = sel_valid_s && (sel_x_s < W_L) && (sel_y_s < H_L) && (sel_c_s != TRANSP);
  end

  // A frame_start outside IDLE (SWAP included) is dropped and counted, saturating.
  always_comb begin
    overrun_s = overrun_r;
    if (bus.frame_start && (state_r != ST_IDLE) && (overrun_r != 8'hFF)) begin
      overrun_s = overrun_r + 8'd1;
    end else begin
      overrun_s = overrun_r;
    end
  end

  // Next-state and next-output logic; draw_x/draw_y double as the clear raster counters.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    cl_start_s   = {NC{1'b0}};
    draw_x_s     = draw_x_r;
    draw_y_s     = draw_y_r;
    draw_color_s = draw_color_r;
    draw_we_s    = 1'b0;
    swap_req_s   = 1'b0;
    busy_s       = busy_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.frame_start) begin
          state_s      = ST_CLEAR;
          draw_x_s     = 10'd0;
          draw_y_s     = 10'd0;
          draw_color_s = BG_COLOR;
          draw_we_s    = 1'b1;
          busy_s       = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        if ((draw_x_r == X_LAST) && (draw_y_r == Y_LAST)) begin
          if (NCLIENT == 0) begin
            state_s    = ST_SWAP;
            swap_req_s = 1'b1;
            busy_s     = 1'b0;
          end else begin
            state_s    = ST_CLIENT;
            idx_s      = {IW{1'b0}};
            cl_start_s = NC'(1);
          end
        end else begin
          draw_we_s    = 1'b1;
          draw_color_s = BG_COLOR;
          if (draw_x_r == X_LAST) begin
            draw_x_s = 10'd0;
            draw_y_s = draw_y_r + 10'd1;
          end else begin
            draw_x_s = draw_x_r + 10'd1;
          end
        end
      end

      ST_CLIENT: begin
        // The pixel seen with cl_done is still registered here and drains in the next state.
        if (pix_ok_s) begin
          draw_x_s     = sel_x_s;
          draw_y_s     = sel_y_s;
          draw_color_s = sel_c_s;
          draw_we_s    = 1'b1;
        end else begin
          draw_we_s = 1'b0;
        end
        if (sel_done_s) begin
          if (idx_r == IDX_LAST) begin
            state_s    = ST_SWAP;
            swap_req_s = 1'b1;
            busy_s     = 1'b0;
          end else begin
            idx_s      = idx_r + IW'(1);
            cl_start_s = NC'(1) << (int'(idx_r) + 1);
          end
        end else begin
          state_s = ST_CLIENT;
        end
      end

      ST_SWAP: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r      <= ST_IDLE;
      idx_r        <= {IW{1'b0}};
      cl_start_r   <= {NC{1'b0}};
      draw_x_r     <= 10'd0;
      draw_y_r     <= 10'd0;
      draw_color_r <= 8'd0;
      draw_we_r    <= 1'b0;
      swap_req_r   <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 8'd0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      cl_start_r   <= cl_start_s;
      draw_x_r     <= draw_x_s;
      draw_y_r     <= draw_y_s;
      draw_color_r <= draw_color_s;
      draw_we_r    <= draw_we_s;
      swap_req_r   <= swap_req_s;
      busy_r       <= busy_s;
      overrun_r    <= overrun_s;
    end
  end

  assign bus.cl_start    = cl_start_r;
  assign bus.draw_x      = draw_x_r;
  assign bus.draw_y      = draw_y_r;
  assign bus.draw_color  = draw_color_r;
  assign bus.draw_we     = draw_we_r;
  assign bus.swap_req    = swap_req_r;
  assign bus.busy        = busy_r;
  assign bus.overrun_cnt = overrun_r;
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Bench for frame_draw_scheduler: one full-size frame, then many randomized frames on a
// small-raster instance, each cycle compared against a frame-timeline reference model.
module tb_frame_draw_scheduler;
  typedef struct packed {
    logic       v;
    logic       d;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] c;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fs  = 1'b0;
  logic [1:0]  cv  = 2'b00;
  logic [1:0]  cd  = 2'b00;
  logic [19:0] cx  = 20'd0;
  logic [19:0] cy  = 20'd0;
  logic [15:0] cc  = 16'd0;
  bit          sel = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int         mw = 320;
  int         mh = 240;
  logic [7:0] mbg = 8'h00;
  logic       e_busy, e_swap, e_we;
  logic [1:0] e_start;
  logic [9:0] lx, ly;
  logic [7:0] lc;
  logic [7:0] ovr_m;
  pix_t       script[$];

  frame_draw_if #(.NCLIENT(2)) bus_f ();
  frame_draw_if #(.NCLIENT(2)) bus_s ();

  frame_draw_scheduler #(.W(320), .H(240), .NCLIENT(2), .BG_COLOR(8'h00), .TRANSP(8'hFF)) dut (
    .Clk(clk), .Reset(rst), .bus(bus_f));
  frame_draw_scheduler #(.W(16), .H(8), .NCLIENT(2), .BG_COLOR(8'h3C), .TRANSP(8'hFF)) dut_s (
    .Clk(clk), .Reset(rst), .bus(bus_s));

  assign bus_f.frame_start = fs;
  assign bus_f.cl_valid    = cv;
  assign bus_f.cl_done     = cd;
  assign bus_f.cl_x        = cx;
  assign bus_f.cl_y        = cy;
  assign bus_f.cl_color    = cc;
  assign bus_s.frame_start = fs;
  assign bus_s.cl_valid    = cv;
  assign bus_s.cl_done     = cd;
  assign bus_s.cl_x        = cx;
  assign bus_s.cl_y        = cy;
  assign bus_s.cl_color    = cc;

  logic [40:0] obs_v;
  assign obs_v = sel ?
    {bus_s.busy, bus_s.swap_req, bus_s.cl_start, bus_s.draw_we, bus_s.draw_x, bus_s.draw_y,
     bus_s.draw_color, bus_s.overrun_cnt} :
    {bus_f.busy, bus_f.swap_req, bus_f.cl_start, bus_f.draw_we, bus_f.draw_x, bus_f.draw_y,
     bus_f.draw_color, bus_f.overrun_cnt};

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [40:0] got, input logic [40:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string tag);
    check_val(tag, obs_v, {e_busy, e_swap, e_start, e_we, lx, ly, lc, ovr_m});
  endtask

  function automatic logic [7:0] bump(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // Client act is driven from e; every other client gets random on-screen noise.
  task automatic drive_clients(input int act, input pix_t e);
    for (int c = 0; c < 2; c++) begin
      if (c == act) begin
        cv[c] = e.v;
        cd[c] = e.d;
        cx[10*c +: 10] = e.x;
        cy[10*c +: 10] = e.y;
        cc[8*c +: 8]   = e.c;
      end else begin
        cv[c] = 1'($urandom_range(1));
        cd[c] = 1'($urandom_range(1));
        cx[10*c +: 10] = 10'($urandom_range(mw - 1));
        cy[10*c +: 10] = 10'($urandom_range(mh - 1));
        cc[8*c +: 8]   = 8'($urandom_range(254));
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      fs = 1'b0;
      drive_clients(-1, '0);
      e_busy = 1'b0; e_swap = 1'b0; e_start = 2'b00; e_we = 1'b0;
      check_cycle("idle");
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fs  = 1'b0;
    drive_clients(-1, '0);
    tick();
    tick();
    e_busy = 1'b0; e_swap = 1'b0; e_start = 2'b00; e_we = 1'b0;
    lx = 10'd0; ly = 10'd0; lc = 8'd0; ovr_m = 8'd0;
    check_cycle("reset");
    rst = 1'b0;
  endtask

  // One frame: frame_start in IDLE, W*H clear writes, the scripted client phases, one swap cycle.
  task automatic run_frame(input int fs_clear_n, input int fs_rate, input bit fs_swap, input int rst_at);
    int   p;
    bit   pend;
    pix_t e;
    logic [9:0] px, py;
    logic [7:0] pc;
    fs = 1'b1;
    drive_clients(-1, '0);
    e_busy = 1'b0; e_swap = 1'b0; e_start = 2'b00; e_we = 1'b0;
    check_cycle("start");
    tick();
    for (int k = 0; k < mw * mh; k++) begin
      fs = ((k % 10 == 5) && (k / 10 < fs_clear_n)) || ($urandom_range(99) < fs_rate);
      drive_clients(-1, '0);
      e_busy = 1'b1; e_swap = 1'b0; e_start = 2'b00; e_we = 1'b1;
      lx = 10'(k % mw); ly = 10'(k / mw); lc = mbg;
      if (k == rst_at) rst = 1'b1;
      check_cycle("clear");
      if (fs) ovr_m = bump(ovr_m);
      tick();
      if (k == rst_at) begin
        rst = 1'b0;
        fs  = 1'b0;
        lx = 10'd0; ly = 10'd0; lc = 8'd0; ovr_m = 8'd0;
        return;
      end
    end
    pend = 1'b0;
    px = 10'd0; py = 10'd0; pc = 8'd0;
    p = 0;
    for (int i = 0; i < 2; i++) begin
      int  j;
      bit  done;
      j = 0;
      done = 1'b0;
      while (!done && p < script.size()) begin
        e = script[p];
        p++;
        fs = ($urandom_range(99) < fs_rate);
        drive_clients(i, e);
        e_busy = 1'b1; e_swap = 1'b0; e_we = pend;
        e_start = (j == 0) ? 2'(1 << i) : 2'b00;
        if (pend) begin lx = px; ly = py; lc = pc; end
        check_cycle((j == 0) ? "client_first" : "client");
        pend = e.v && (int'(e.x) < mw) && (int'(e.y) < mh) && (e.c != 8'hFF);
        px = e.x; py = e.y; pc = e.c;
        if (fs) ovr_m = bump(ovr_m);
        done = e.d;
        j++;
        tick();
      end
    end
    fs = fs_swap || ($urandom_range(99) < fs_rate);
    drive_clients(-1, '0);
    e_busy = 1'b0; e_swap = 1'b1; e_start = 2'b00; e_we = pend;
    if (pend) begin lx = px; ly = py; lc = pc; end
    check_cycle("swap");
    if (fs) ovr_m = bump(ovr_m);
    tick();
    fs = 1'b0;
  endtask

  task automatic gen_script(input int maxlen);
    script.delete();
    for (int i = 0; i < 2; i++) begin
      int n;
      n = int'($urandom_range(maxlen, 1));
      for (int j = 0; j < n; j++) begin
        pix_t e;
        e.v = ($urandom_range(9) < 7);
        e.d = (j == n - 1);
        case ($urandom_range(4))
          0: e.x = 10'(mw - 1);
          1: e.x = 10'(mw);
          2: e.x = 10'($urandom_range(1023));
          default: e.x = 10'($urandom_range(mw - 1));
        endcase
        case ($urandom_range(4))
          0: e.y = 10'(mh - 1);
          1: e.y = 10'(mh);
          2: e.y = 10'($urandom_range(1023));
          default: e.y = 10'($urandom_range(mh - 1));
        endcase
        e.c = ($urandom_range(4) == 0) ? 8'hFF : 8'($urandom_range(254));
        script.push_back(e);
      end
    end
  endtask

  initial begin
    // Full-size frame: fixed client-0 sequence, client 1 done at once, 3 overruns in clear, 1 at swap.
    sel = 1'b0; mw = 320; mh = 240; mbg = 8'h00;
    do_reset();
    idle_cycles(2);
    script.delete();
    script.push_back({1'b1, 1'b0, 10'd5,   10'd7,   8'h12});
    script.push_back({1'b1, 1'b0, 10'd319, 10'd239, 8'h34});
    script.push_back({1'b1, 1'b0, 10'd320, 10'd0,   8'h56});
    script.push_back({1'b1, 1'b1, 10'd3,   10'd3,   8'hFF});
    script.push_back({1'b0, 1'b1, 10'd0,   10'd0,   8'h00});
    run_frame(3, 0, 1'b1, -1);
    idle_cycles(2);
    check_val("overrun_full", {33'd0, obs_v[7:0]}, {33'd0, 8'd4});

    // Small raster: randomized frames and clients.
    sel = 1'b1; mw = 16; mh = 8; mbg = 8'h3C;
    do_reset();
    idle_cycles(1);
    for (int f = 0; f < 10; f++) begin
      gen_script(10);
      run_frame(int'($urandom_range(3)), 0, 1'($urandom_range(1)), -1);
      idle_cycles(int'($urandom_range(3)));
    end

    // Reset in the middle of the clear (row 4), then a clean frame from (0,0).
    gen_script(6);
    run_frame(2, 0, 1'b0, mw * 4 + 3);
    idle_cycles(3);
    gen_script(6);
    run_frame(0, 0, 1'b0, -1);
    idle_cycles(1);

    // Frame_start every busy cycle until the overrun counter saturates.
    for (int f = 0; f < 3; f++) begin
      gen_script(8);
      run_frame(0, 100, 1'b1, -1);
    end
    idle_cycles(2);
    check_val("overrun_sat", {33'd0, obs_v[7:0]}, {33'd0, 8'hFF});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
